alert_event_queue: RTL

ALERT_EVENT_QUEUE -- requirements
Module: alert_event_queue

---
 rtl/alert_event_queue_if.sv | 12 +
 rtl/alert_event_queue.sv | 88 ++++++++
 2 files changed

// File: rtl/alert_event_queue_if.sv
// Event record stream from alert_event_queue to its consumer (valid/ready handshake).
interface alert_event_queue_if #(
  parameter int TS_W = 8
);
  logic            evt_valid;
  logic            evt_ready;
  logic            evt_kind;
  logic [TS_W-1:0] evt_ts;

  modport master (output evt_valid, evt_kind, evt_ts, input evt_ready);
  modport slave  (input evt_valid, evt_kind, evt_ts, output evt_ready);
endinterface

// File: rtl/alert_event_queue.sv
// Rising-edge detector on high/low alerts feeding a small record FIFO.
// Define ALERT_TIMESTAMP_EN to stamp each record with a free-running cycle counter.
module alert_event_queue #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 high_alert,
  input  logic                 low_alert,
  input  logic                 ovf_clear,
  alert_event_queue_if.master  evt,
  output logic                 overflow,
  output logic [7:0]           evt_count
);
  localparam int AW = $clog2(DEPTH);

  logic          hi_q, lo_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic [DEPTH-1:0] kind_mem;

  logic hi_evt, lo_evt, push_req, full, valid, pop, push_ok, drop;

  always_comb begin
    hi_evt   = high_alert & ~hi_q;
    lo_evt   = low_alert  & ~lo_q;
    push_req = hi_evt | lo_evt;
    valid    = (occ != '0);
    full     = (occ == (AW+1)'(DEPTH));
    pop      = valid & evt.evt_ready;
    // a full queue still takes the push when the head leaves this same edge
    push_ok  = push_req & (~full | pop);
    // a coincident low edge always loses to the high edge
    drop     = (push_req & ~push_ok) | (hi_evt & lo_evt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q      <= 1'b0;
      lo_q      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      overflow  <= 1'b0;
      evt_count <= 8'd0;
    end else begin
      hi_q <= high_alert;
      lo_q <= low_alert;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
      if (push_ok && evt_count != 8'hFF) evt_count <= evt_count + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) kind_mem[wr_ptr] <= hi_evt;
  end

  assign evt.evt_valid = valid;
  assign evt.evt_kind  = valid & kind_mem[rd_ptr];

`ifdef ALERT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end

  always_ff @(posedge clock) begin
    if (push_ok) ts_mem[wr_ptr] <= ts_q;
  end

  assign evt.evt_ts = valid ? ts_mem[rd_ptr] : '0;
`else
  assign evt.evt_ts = '0;
`endif

endmodule
